// File: rtl/team_04_keypad_scanner_if.sv
// rtl/team_04_keypad_scanner_if.sv - key event bus from the keypad scanner to application logic
interface team_04_keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  modport master (output key_code, key_valid, key_held, multi_key);
  modport slave  (input  key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/team_04_keypad_scanner.sv
// rtl/team_04_keypad_scanner.sv - 4x4 matrix keypad scanner with whole-scan debounce
module team_04_keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic [3:0]                row_in,
  output logic [3:0]                col_out,
  team_04_keypad_scanner_if.master  key
);
  localparam int         DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  logic [3:0]    row_meta, row_s;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [1:0]    hit_cnt;
  logic [3:0]    first_code;
  state_t        state;
  logic [3:0]    stab;
  logic [3:0]    cand;

  logic          last_dwell, scan_end;
  logic [1:0]    col_hits, col_row;
  logic [1:0]    scan_cnt;
  logic [3:0]    scan_code;
  logic [3:0]    stab_inc;

  // Synchronizer is deliberately outside the enable clear.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      row_meta <= 4'b0000;
      row_s    <= 4'b0000;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  assign col_out    = en ? 4'(4'b0001 << col_idx) : 4'b0000;
  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign scan_end   = last_dwell && (col_idx == 2'd3);
  assign stab_inc   = stab + 4'd1;

  // Fold this column's sample into the running scan tally; lowest row wins.
  always_comb begin
    col_hits  = 2'd0;
    col_row   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_s[r]) begin
        col_row  = 2'(r);
        col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
      end
    end
    scan_cnt  = hit_cnt;
    scan_code = first_code;
    if (col_hits != 2'd0) begin
      if (hit_cnt == 2'd0) begin
        scan_code = {col_idx, col_row};
      end
      scan_cnt = (hit_cnt == 2'd0 && col_hits == 2'd1) ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst || !en) begin
      dwell         <= '0;
      col_idx       <= 2'd0;
      hit_cnt       <= 2'd0;
      first_code    <= 4'd0;
      state         <= IDLE;
      stab          <= 4'd0;
      cand          <= 4'd0;
      key.key_code  <= 4'd0;
      key.key_valid <= 1'b0;
      key.key_held  <= 1'b0;
      key.multi_key <= 1'b0;
    end else begin
      key.key_valid <= 1'b0;
      if (last_dwell) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        dwell <= dwell + DW'(1);
      end
      if (last_dwell && !scan_end) begin
        hit_cnt    <= scan_cnt;
        first_code <= scan_code;
      end
      if (scan_end) begin
        hit_cnt       <= 2'd0;
        first_code    <= 4'd0;
        key.multi_key <= (scan_cnt == 2'd2);
        case (state)
          IDLE: begin
            if (scan_cnt == 2'd1) begin
              cand <= scan_code;
              stab <= 4'd1;
              if (DB == 4'd1) begin
                state         <= PRESSED;
                key.key_code  <= scan_code;
                key.key_valid <= 1'b1;
                key.key_held  <= 1'b1;
              end else begin
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (scan_cnt == 2'd1 && scan_code == cand) begin
              if (stab_inc == DB) begin
                state         <= PRESSED;
                key.key_code  <= cand;
                key.key_valid <= 1'b1;
                key.key_held  <= 1'b1;
              end else begin
                stab <= stab_inc;
              end
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (scan_cnt == 2'd0) begin
              stab <= 4'd1;
              if (DB == 4'd1) begin
                state        <= IDLE;
                key.key_held <= 1'b0;
              end else begin
                state <= REL;
              end
            end
          end
          REL: begin
            if (scan_cnt == 2'd0) begin
              if (stab_inc == DB) begin
                state        <= IDLE;
                key.key_held <= 1'b0;
              end else begin
                stab <= stab_inc;
              end
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_team_04_keypad_scanner.sv
// tb/tb_team_04_keypad_scanner.sv - directed bench for team_04_keypad_scanner
module tb_team_04_keypad_scanner;
  logic        clk;
  logic        nrst;
  logic        en;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int first_pulse = 0;
  int tick_cnt = 0;

  team_04_keypad_scanner_if kif ();

  team_04_keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .row_in  (row_in),
    .col_out (col_out),
    .key     (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: closed key (c,r) is bit c*4+r of keys.
  always_comb begin
    row_in = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && col_out[c]) row_in[r] = 1'b1;
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          pulses;
    logic        held;
    logic [3:0]  code;
    logic        multi;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tick_cnt++;
    if (kif.key_valid) begin
      pulse_cnt++;
      if (first_pulse == 0) first_pulse = tick_cnt;
    end
  endtask

  task automatic run_scans(input int n);
    repeat (n * 32) tick();
  endtask

  // Clear via en or nrst, then re-enable with the key still closed.
  task automatic clear_and_recover(input bit use_rst, input string tag);
    if (use_rst) nrst = 1'b0; else en = 1'b0;
    #1;
    check({tag, "_col_during"}, int'(col_out), use_rst ? 1 : 0);
    tick();
    check({tag, "_held"}, int'(kif.key_held), 0);
    check({tag, "_code"}, int'(kif.key_code), 0);
    check({tag, "_valid"}, int'(kif.key_valid), 0);
    tick();
    tick();
    nrst = 1'b1;
    en = 1'b1;
    #1;
    check({tag, "_col_restart"}, int'(col_out), 1);
    pulse_cnt = 0;
    first_pulse = 0;
    tick_cnt = 0;
    run_scans(3);
    check({tag, "_pulses"}, pulse_cnt, 1);
    check({tag, "_pulse_tick"}, first_pulse, 64);
    check({tag, "_held_after"}, int'(kif.key_held), 1);
    check({tag, "_code_after"}, int'(kif.key_code), 9);
  endtask

  initial begin
    vecs[0]  = '{16'h0200, 1,  0, 1'b0, 4'h0, 1'b0};
    vecs[1]  = '{16'h0200, 1,  1, 1'b1, 4'h9, 1'b0};
    vecs[2]  = '{16'h0200, 10, 0, 1'b1, 4'h9, 1'b0};
    vecs[3]  = '{16'h0000, 1,  0, 1'b1, 4'h9, 1'b0};
    vecs[4]  = '{16'h0000, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[5]  = '{16'h0080, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[6]  = '{16'h0000, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[7]  = '{16'h0080, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[8]  = '{16'h0000, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[9]  = '{16'h0080, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[10] = '{16'h0000, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[11] = '{16'h4001, 1,  0, 1'b0, 4'h9, 1'b1};
    vecs[12] = '{16'h4001, 1,  0, 1'b0, 4'h9, 1'b1};
    vecs[13] = '{16'h4000, 1,  0, 1'b0, 4'h9, 1'b0};
    vecs[14] = '{16'h4000, 1,  1, 1'b1, 4'hE, 1'b0};
    vecs[15] = '{16'h0000, 2,  0, 1'b0, 4'hE, 1'b0};

    nrst = 1'b0;
    en   = 1'b1;
    keys = 16'h0000;
    repeat (3) tick();
    check("rst_col", int'(col_out), 1);
    check("rst_code", int'(kif.key_code), 0);
    check("rst_valid", int'(kif.key_valid), 0);
    check("rst_held", int'(kif.key_held), 0);
    check("rst_multi", int'(kif.multi_key), 0);
    nrst = 1'b1;
    repeat (8) tick();
    check("col_step", int'(col_out), 2);
    repeat (24) tick();
    check("col_wrap", int'(col_out), 1);

    for (int i = 0; i < 16; i++) begin
      keys = vecs[i].keys;
      pulse_cnt = 0;
      run_scans(vecs[i].scans);
      check($sformatf("vec%0d_pulses", i), pulse_cnt, vecs[i].pulses);
      check($sformatf("vec%0d_held", i), int'(kif.key_held), int'(vecs[i].held));
      check($sformatf("vec%0d_code", i), int'(kif.key_code), int'(vecs[i].code));
      check($sformatf("vec%0d_multi", i), int'(kif.multi_key), int'(vecs[i].multi));
    end

    keys = 16'h0200;
    pulse_cnt = 0;
    first_pulse = 0;
    tick_cnt = 0;
    run_scans(2);
    check("press_pulses", pulse_cnt, 1);
    check("press_latency", first_pulse, 64);
    repeat (5) tick();
    clear_and_recover(1'b0, "en_pressed");
    clear_and_recover(1'b1, "rst_pressed");

    keys = 16'h0000;
    run_scans(2);
    check("release_held", int'(kif.key_held), 0);
    keys = 16'h0200;
    run_scans(1);
    repeat (10) tick();
    clear_and_recover(1'b0, "en_cand");

    keys = 16'h0000;
    run_scans(2);
    keys = 16'h0200;
    run_scans(1);
    clear_and_recover(1'b1, "rst_cand");

    // en falls exactly on the scan-end cycle that would have accepted.
    keys = 16'h0000;
    run_scans(2);
    keys = 16'h0200;
    run_scans(1);
    repeat (31) tick();
    pulse_cnt = 0;
    en = 1'b0;
    tick();
    check("en_scanend_valid", int'(kif.key_valid), 0);
    check("en_scanend_held", int'(kif.key_held), 0);
    check("en_scanend_pulses", pulse_cnt, 0);
    en = 1'b1;
    run_scans(2);
    check("en_scanend_repress", pulse_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
